// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage.
// DECODE_MULDIV_EN adds the muldiv fields to decode_ctrl_t.
package decode_pkg;

  localparam int unsigned ILEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  // Main ALU op follows funct3 so R/I types decode directly.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_t;

  // Secondary adder: branch target (pc+imm) or link value (pc+4).
  typedef enum logic [1:0] {
    ALU2_NONE   = 2'b00,
    ALU2_TARGET = 2'b01,
    ALU2_LINK   = 2'b10
  } alu2_op_t;

  localparam logic [2:0] CMP_EQ     = 3'b000;
  localparam logic [2:0] CMP_NE     = 3'b001;
  localparam logic [2:0] CMP_ALWAYS = 3'b010;
  localparam logic [2:0] CMP_LT     = 3'b100;
  localparam logic [2:0] CMP_GE     = 3'b101;
  localparam logic [2:0] CMP_LTU    = 3'b110;
  localparam logic [2:0] CMP_GEU    = 3'b111;

  typedef struct packed {
    logic [ILEN-1:0]  imm;
    alu_op_t          alu_op;
    logic             alu_alt;
    alu2_op_t         alu2_op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic             sel_pc_a;
    logic             sel_imm_b;
    logic             wb;
    logic             mem;
    logic             mem_read;
    logic [2:0]       mem_funct;
    logic             branch;
    logic [2:0]       comparison;
`ifdef DECODE_MULDIV_EN
    logic             muldiv;
    logic [2:0]       muldiv_op;
`endif
  } decode_ctrl_t;

  localparam int unsigned CTRL_W = $bits(decode_ctrl_t);

  function automatic logic [ILEN-1:0] imm_i(input logic [ILEN-1:0] x);
    return {{20{x[31]}}, x[31:20]};
  endfunction

  function automatic logic [ILEN-1:0] imm_s(input logic [ILEN-1:0] x);
    return {{20{x[31]}}, x[31:25], x[11:7]};
  endfunction

  function automatic logic [ILEN-1:0] imm_b(input logic [ILEN-1:0] x);
    return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
  endfunction

  function automatic logic [ILEN-1:0] imm_u(input logic [ILEN-1:0] x);
    return {x[31:12], 12'b0};
  endfunction

  function automatic logic [ILEN-1:0] imm_j(input logic [ILEN-1:0] x);
    return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I instruction decoder: instr -> control bundle + illegal flag.
// DECODE_MULDIV_EN enables decoding of the M-extension R-type group.
module decode_logic
  import decode_pkg::*;
(
  input  logic [ILEN-1:0] i_instr,
  output decode_ctrl_t    o_ctrl_c,
  output logic            o_illegal_c
);

  logic [4:0]   w_opcode;
  logic [4:0]   w_rd;
  logic [4:0]   w_rs1;
  logic [4:0]   w_rs2;
  logic [2:0]   w_funct3;
  logic [6:0]   w_funct7;
  logic         w_wb_ok;
  decode_ctrl_t w_ctrl;
  logic         w_illegal;

  assign w_opcode = i_instr[6:2];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_funct7 = i_instr[31:25];
  assign w_wb_ok  = (w_rd != 5'd0);

  always_comb begin
    w_ctrl    = decode_ctrl_t'('0);
    w_illegal = 1'b0;
    if (i_instr[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (w_opcode)
        OP_R: begin
          w_ctrl.rd = w_rd;
          w_ctrl.ra = w_rs1;
          w_ctrl.rb = w_rs2;
          w_ctrl.wb = w_wb_ok;
          case (w_funct7)
            7'h00: w_ctrl.alu_op = alu_op_t'(w_funct3);
            7'h20: begin
              // Only SUB and SRA have an alternate form.
              w_ctrl.alu_op  = alu_op_t'(w_funct3);
              w_ctrl.alu_alt = 1'b1;
              w_illegal      = (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
            end
`ifdef DECODE_MULDIV_EN
            7'h01: begin
              w_ctrl.muldiv    = 1'b1;
              w_ctrl.muldiv_op = w_funct3;
            end
`endif
            default: w_illegal = 1'b1;
          endcase
        end
        OP_IMM: begin
          w_ctrl.imm       = imm_i(i_instr);
          w_ctrl.alu_op    = alu_op_t'(w_funct3);
          w_ctrl.alu_alt   = (w_funct3 == 3'b101) && i_instr[30];
          w_ctrl.rd        = w_rd;
          w_ctrl.ra        = w_rs1;
          w_ctrl.sel_imm_b = 1'b1;
          w_ctrl.wb        = w_wb_ok;
        end
        OP_LOAD: begin
          w_ctrl.imm       = imm_i(i_instr);
          w_ctrl.rd        = w_rd;
          w_ctrl.ra        = w_rs1;
          w_ctrl.sel_imm_b = 1'b1;
          w_ctrl.wb        = w_wb_ok;
          w_ctrl.mem       = 1'b1;
          w_ctrl.mem_read  = 1'b1;
          w_ctrl.mem_funct = w_funct3;
        end
        OP_STORE: begin
          w_ctrl.imm       = imm_s(i_instr);
          w_ctrl.ra        = w_rs1;
          w_ctrl.rb        = w_rs2;
          w_ctrl.sel_imm_b = 1'b1;
          w_ctrl.mem       = 1'b1;
          w_ctrl.mem_funct = w_funct3;
        end
        OP_BRANCH: begin
          w_ctrl.imm        = imm_b(i_instr);
          w_ctrl.ra         = w_rs1;
          w_ctrl.rb         = w_rs2;
          w_ctrl.alu2_op    = ALU2_TARGET;
          w_ctrl.branch     = 1'b1;
          w_ctrl.comparison = w_funct3;
          // funct3 010/011 are not branches; 010 is reserved for jumps.
          w_illegal         = (w_funct3[2:1] == 2'b01);
        end
        OP_LUI: begin
          w_ctrl.imm       = imm_u(i_instr);
          w_ctrl.rd        = w_rd;
          w_ctrl.sel_imm_b = 1'b1;
          w_ctrl.wb        = w_wb_ok;
        end
        OP_AUIPC: begin
          w_ctrl.imm       = imm_u(i_instr);
          w_ctrl.rd        = w_rd;
          w_ctrl.sel_pc_a  = 1'b1;
          w_ctrl.sel_imm_b = 1'b1;
          w_ctrl.wb        = w_wb_ok;
        end
        OP_JAL: begin
          w_ctrl.imm        = imm_j(i_instr);
          w_ctrl.rd         = w_rd;
          w_ctrl.sel_pc_a   = 1'b1;
          w_ctrl.sel_imm_b  = 1'b1;
          w_ctrl.alu2_op    = ALU2_LINK;
          w_ctrl.wb         = w_wb_ok;
          w_ctrl.branch     = 1'b1;
          w_ctrl.comparison = CMP_ALWAYS;
        end
        OP_JALR: begin
          w_ctrl.imm        = imm_i(i_instr);
          w_ctrl.rd         = w_rd;
          w_ctrl.ra         = w_rs1;
          w_ctrl.sel_imm_b  = 1'b1;
          w_ctrl.alu2_op    = ALU2_LINK;
          w_ctrl.wb         = w_wb_ok;
          w_ctrl.branch     = 1'b1;
          w_ctrl.comparison = CMP_ALWAYS;
        end
        OP_SYSTEM: w_illegal = 1'b0;
        default:   w_illegal = 1'b1;
      endcase
    end
  end

  // Illegal instructions must not carry any side-effecting control.
  assign o_ctrl_c    = w_illegal ? decode_ctrl_t'('0) : w_ctrl;
  assign o_illegal_c = w_illegal;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: instruction FIFO, decoder on the head, output register.
// Build with DECODE_MULDIV_EN to decode the M-extension R-type group.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned IBUF_DEPTH  = 2,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ILEN-1:0]        in_instr,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output decode_ctrl_t           out_ctrl,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned CNT_W = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

  logic [XLEN-1:0]        r_fifo_pc    [IBUF_DEPTH];
  logic [ILEN-1:0]        r_fifo_instr [IBUF_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_out_valid;
  logic [XLEN-1:0]        r_out_pc;
  decode_ctrl_t           r_out_ctrl;
  logic                   r_out_illegal;
  logic [STALL_CNT_W-1:0] r_stall;

  logic                   w_push;
  logic                   w_load;
  decode_ctrl_t           w_ctrl;
  logic                   w_illegal;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(IBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready = (r_count < CNT_W'(IBUF_DEPTH)) && !flush;
  assign w_push   = in_valid && in_ready;
  assign w_load   = (r_count != '0) && (!r_out_valid || out_ready) && !flush;

  decode_logic u_decode_logic (
    .i_instr     (r_fifo_instr[r_rd_ptr]),
    .o_ctrl_c    (w_ctrl),
    .o_illegal_c (w_illegal)
  );

  // FIFO payload storage; no reset needed, validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= in_pc;
      r_fifo_instr[r_wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_load) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register; payload holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_pc      <= '0;
      r_out_ctrl    <= decode_ctrl_t'('0);
      r_out_illegal <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid   <= 1'b1;
      r_out_pc      <= r_fifo_pc[r_rd_ptr];
      r_out_ctrl    <= w_ctrl;
      r_out_illegal <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (r_out_valid && !out_ready && (r_stall != '1)) begin
      r_stall <= r_stall + STALL_CNT_W'(1);
    end
  end

  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_pc;
  assign out_ctrl     = r_out_ctrl;
  assign out_illegal  = r_out_illegal;
  assign stall_cycles = r_stall;

endmodule
